instruction_fetch_control: RTL

Stage-1 fetch controller sitting directly upstream of the instruction memory and directly downstream of the redirect logic in later stages. It generates the word-aligned fetch address each cycle and tracks the one-cycle read latency of the synchronous instruction memory. It pairs each returned instruction with its PC and presents the pair to decode with a valid/stall handshake. A one-entry hold register ensures that no instruction is lost or duplicated when decode stalls.

---
 rtl/instruction_fetch_control.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/instruction_fetch_control.sv
// instruction_fetch_control: stage-1 fetch controller.
// Drives the word-aligned fetch address into a synchronous (1-cycle) instruction
// memory, pairs each returned word with its PC and hands it to decode through a
// valid/stall handshake. A one-entry hold register keeps a stalled instruction
// alive while the memory read behind it is discarded and re-issued later.
// Optional build macro: FETCH_PERF_COUNTERS_EN adds perf_fetched,
// perf_squashed and perf_stall_cycles counter outputs.
module instruction_fetch_control #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall_in,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] fetch_addr,
  input  logic [31:0] mem_instruction,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instruction
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_squashed,
  output logic [31:0] perf_stall_cycles
`endif
);

  localparam int unsigned WORD_W = 32;

  // RUN: no held entry; HOLD: hold register carries the decode-visible instruction.
  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [WORD_W-1:0] fetch_addr_q, fetch_addr_d;
  logic              inflight_valid_q, inflight_valid_d;
  logic [WORD_W-1:0] inflight_pc_q, inflight_pc_d;
  logic [WORD_W-1:0] hold_pc_q, hold_pc_d;
  logic [WORD_W-1:0] hold_instr_q, hold_instr_d;
  logic              hold_valid;
  logic              unused_target_bits;

  // Low address bits of the redirect target are forced to zero and never read.
  assign unused_target_bits = ^redirect_target[1:0];

  assign hold_valid = (state_q == HOLD);

  // State registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q          <= RUN;
      fetch_addr_q     <= RESET_PC;
      inflight_valid_q <= 1'b0;
      inflight_pc_q    <= '0;
      hold_pc_q        <= '0;
      hold_instr_q     <= '0;
    end else begin
      state_q          <= state_d;
      fetch_addr_q     <= fetch_addr_d;
      inflight_valid_q <= inflight_valid_d;
      inflight_pc_q    <= inflight_pc_d;
      hold_pc_q        <= hold_pc_d;
      hold_instr_q     <= hold_instr_d;
    end
  end

  // Next-state logic: redirect beats stall beats advance.
  always_comb begin
    state_d          = state_q;
    fetch_addr_d     = fetch_addr_q;
    inflight_valid_d = inflight_valid_q;
    inflight_pc_d    = inflight_pc_q;
    hold_pc_d        = hold_pc_q;
    hold_instr_d     = hold_instr_q;

    if (redirect_valid) begin
      fetch_addr_d     = {redirect_target[31:2], 2'b00};
      inflight_valid_d = 1'b0;
      state_d          = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (!stall_in) begin
            inflight_pc_d    = fetch_addr_q;
            inflight_valid_d = 1'b1;
            fetch_addr_d     = fetch_addr_q + WORD_W'(4);
          end else begin
            // Park the live instruction; the read behind it is dropped and
            // fetch_addr is held so that read is issued again on release.
            if (inflight_valid_q) begin
              hold_pc_d    = inflight_pc_q;
              hold_instr_d = mem_instruction;
              state_d      = HOLD;
            end
            inflight_valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (!stall_in) begin
            inflight_pc_d    = fetch_addr_q;
            inflight_valid_d = 1'b1;
            fetch_addr_d     = fetch_addr_q + WORD_W'(4);
            state_d          = RUN;
          end
        end
        default: begin
          state_d          = RUN;
          inflight_valid_d = 1'b0;
        end
      endcase
    end
  end

  // Output select: hold entry in HOLD, memory pass-through in RUN.
  always_comb begin
    out_valid       = (hold_valid | inflight_valid_q) & ~redirect_valid;
    out_pc          = '0;
    out_instruction = hold_valid ? hold_instr_q : mem_instruction;
    if (out_valid) begin
      out_pc = hold_valid ? hold_pc_q : inflight_pc_q;
    end
  end

  assign fetch_addr = fetch_addr_q;

`ifdef FETCH_PERF_COUNTERS_EN
  logic [WORD_W-1:0] perf_fetched_q, perf_squashed_q, perf_stall_cycles_q;
  logic [WORD_W-1:0] squash_cnt;

  // In HOLD the in-flight slot is always empty, so at most one entry is squashed
  // per redirect, but both flags are summed to stay exact.
  assign squash_cnt = WORD_W'(inflight_valid_q) + WORD_W'(hold_valid);

  // Performance counters; free-running, wrap at 2^32.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_fetched_q      <= '0;
      perf_squashed_q     <= '0;
      perf_stall_cycles_q <= '0;
    end else begin
      if (out_valid && !stall_in) begin
        perf_fetched_q <= perf_fetched_q + WORD_W'(1);
      end
      if (out_valid && stall_in) begin
        perf_stall_cycles_q <= perf_stall_cycles_q + WORD_W'(1);
      end
      if (redirect_valid) begin
        perf_squashed_q <= perf_squashed_q + squash_cnt;
      end
    end
  end

  assign perf_fetched      = perf_fetched_q;
  assign perf_squashed     = perf_squashed_q;
  assign perf_stall_cycles = perf_stall_cycles_q;
`endif

endmodule
